cnt_rr_sched: RTL

Round-robin scheduler that shares a single W-bit up-counter datapath among NREQ requesters. Each requester asks for a counting burst of a programmed length. The scheduler grants one requester at a time, runs the counter from 0 for that many cycles with `valid` asserted, and signals completion back to the owner. It sits in front of the counter/valid/out datapath and is the only block that starts, sequences and stops it.

---
 rtl/cnt_rr_sched_if.sv | 31 +++
 rtl/cnt_rr_sched.sv | 110 +++++++++++
 2 files changed

// File: rtl/cnt_rr_sched_if.sv
// cnt_rr_sched_if
// Bundles the request side (req, len) and the burst/counter side (ack, owner,
// busy, data, valid, done, out) of the round-robin counter scheduler.
//   master : requester/bench side, drives req and len
//   slave  : scheduler side, drives every status/datapath output
interface cnt_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   ack;
    logic [IDW-1:0]    owner;
    logic              busy;
    logic [W-1:0]      data;
    logic              valid;
    logic [NREQ-1:0]   done;
    logic              out;

    modport master (
        output req, len,
        input  ack, owner, busy, data, valid, done, out
    );

    modport slave (
        input  req, len,
        output ack, owner, busy, data, valid, done, out
    );
endinterface

// File: rtl/cnt_rr_sched.sv
// cnt_rr_sched
// Round-robin scheduler sharing one W-bit up-counter among NREQ requesters.
// A granted requester gets a burst of len_i cycles with valid high and data
// counting 0..len_i-1, followed by a one-cycle done pulse.
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    cnt_rr_sched_if.slave: req/len in; ack/owner/busy/data/valid/done/out
//
// state | meaning
// IDLE  | waiting; arbitrates among req starting at ptr
// RUN   | burst in progress, valid high, data counting
// DONE  | one-cycle completion, done[owner] high
module cnt_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic           clk,
    input  logic           reset,
    cnt_rr_sched_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [W-1:0]   rem;

    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [W-1:0]   gnt_len;

    // First set request at or above ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && bus.req[(int'(ptr) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign gnt_len = bus.len[gnt_idx*W +: W];

    // Combinational view of registered state; no flop of its own.
    assign bus.out = bus.valid & bus.data[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            rem       <= '0;
            bus.ack   <= '0;
            bus.owner <= '0;
            bus.busy  <= 1'b0;
            bus.data  <= '0;
            bus.valid <= 1'b0;
            bus.done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        bus.ack   <= ONE << gnt_idx;
                        bus.owner <= gnt_idx;
                        bus.busy  <= 1'b1;
                        bus.data  <= '0;
                        rem       <= gnt_len;
                        if (gnt_len != '0) begin
                            bus.valid <= 1'b1;
                            state     <= RUN;
                        end else begin
                            // Zero-length burst: grant and completion coincide.
                            bus.valid <= 1'b0;
                            bus.done  <= ONE << gnt_idx;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    bus.ack <= '0;
                    if (rem > W'(1)) begin
                        bus.data <= bus.data + 1'b1;
                        rem      <= rem - 1'b1;
                    end else begin
                        bus.valid <= 1'b0;
                        bus.done  <= ONE << bus.owner;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    bus.ack  <= '0;
                    bus.done <= '0;
                    bus.busy <= 1'b0;
                    ptr      <= (bus.owner == IDW'(NREQ-1)) ? '0 : bus.owner + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
